// File: rtl/dcache_data_write_sched.sv
// Data-array write-port scheduler. Port 0 (refill/replay) normally has priority;
// port 1 (store writeback) is forced through after MAX_WAIT stalled cycles.
module dcache_data_write_sched #(
  parameter int WAY_W    = 8,
  parameter int ADDR_W   = 12,
  parameter int MASK_W   = 2,
  parameter int DATA_W   = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_0_valid,
  output logic              io_in_0_ready,
  input  logic [WAY_W-1:0]  io_in_0_bits_way_en,
  input  logic [ADDR_W-1:0] io_in_0_bits_addr,
  input  logic [MASK_W-1:0] io_in_0_bits_wmask,
  input  logic [DATA_W-1:0] io_in_0_bits_data,
  input  logic              io_in_1_valid,
  output logic              io_in_1_ready,
  input  logic [WAY_W-1:0]  io_in_1_bits_way_en,
  input  logic [ADDR_W-1:0] io_in_1_bits_addr,
  input  logic [DATA_W-1:0] io_in_1_bits_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [WAY_W-1:0]  io_out_bits_way_en,
  output logic [ADDR_W-1:0] io_out_bits_addr,
  output logic [MASK_W-1:0] io_out_bits_wmask,
  output logic [DATA_W-1:0] io_out_bits_data,
  output logic              io_starve
);

  typedef struct packed {
    logic [WAY_W-1:0]  way_en;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_WAIT);

  logic [2:0] cnt;
  logic       starve, load, fire_0, fire_1;
  wr_req_t    req_0, req_1, out_q;

  assign req_0 = {io_in_0_bits_way_en, io_in_0_bits_addr, io_in_0_bits_wmask, io_in_0_bits_data};
  // Store writebacks always cover both banks.
  assign req_1 = {io_in_1_bits_way_en, io_in_1_bits_addr, {MASK_W{1'b1}}, io_in_1_bits_data};

  assign starve    = (cnt == MAX_CNT);
  assign io_starve = starve;
  assign load      = !io_out_valid || io_out_ready;

  // Each ready looks only at the other port's valid, so no valid->ready loop.
  assign io_in_0_ready = load && (starve ? !io_in_1_valid : 1'b1);
  assign io_in_1_ready = load && (starve ? 1'b1 : !io_in_0_valid);

  assign fire_0 = io_in_0_valid && io_in_0_ready;
  assign fire_1 = io_in_1_valid && io_in_1_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_out_valid <= 1'b0;
      out_q        <= '0;
    end else if (load) begin
      io_out_valid <= fire_0 || fire_1;
      if (fire_1)      out_q <= req_1;
      else if (fire_0) out_q <= req_0;
    end
  end

  // Backpressure stalls count too: a waiting port-1 request is waiting regardless of cause.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (io_in_1_valid && !fire_1) begin
      cnt <= starve ? cnt : cnt + 3'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign io_out_bits_way_en = out_q.way_en;
  assign io_out_bits_addr   = out_q.addr;
  assign io_out_bits_wmask  = out_q.wmask;
  assign io_out_bits_data   = out_q.data;

endmodule

// File: tb/tb_dcache_data_write_sched.sv
// Randomized + directed bench for dcache_data_write_sched against a cycle-level
// behavioural model of the arbitration and output stage.
module tb_dcache_data_write_sched;
  localparam int WAY_W = 8, ADDR_W = 12, MASK_W = 2, DATA_W = 128, MAX_WAIT = 4;

  logic clock = 1'b0;
  logic reset;
  logic in0_v, in0_r, in1_v, in1_r, out_v, out_r, starve;
  logic [WAY_W-1:0]  in0_way, in1_way, out_way;
  logic [ADDR_W-1:0] in0_addr, in1_addr, out_addr;
  logic [MASK_W-1:0] in0_mask, out_mask;
  logic [DATA_W-1:0] in0_data, in1_data, out_data;

  dcache_data_write_sched #(.WAY_W(WAY_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W),
                            .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .io_in_0_valid(in0_v), .io_in_0_ready(in0_r), .io_in_0_bits_way_en(in0_way),
    .io_in_0_bits_addr(in0_addr), .io_in_0_bits_wmask(in0_mask), .io_in_0_bits_data(in0_data),
    .io_in_1_valid(in1_v), .io_in_1_ready(in1_r), .io_in_1_bits_way_en(in1_way),
    .io_in_1_bits_addr(in1_addr), .io_in_1_bits_data(in1_data),
    .io_out_valid(out_v), .io_out_ready(out_r), .io_out_bits_way_en(out_way),
    .io_out_bits_addr(out_addr), .io_out_bits_wmask(out_mask), .io_out_bits_data(out_data),
    .io_starve(starve)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int                m_cnt;
  logic              m_ov;
  logic [WAY_W-1:0]  m_way;
  logic [ADDR_W-1:0] m_addr;
  logic [MASK_W-1:0] m_mask;
  logic [DATA_W-1:0] m_data;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ov = 0; m_way = '0; m_addr = '0; m_mask = '0; m_data = '0;
  endtask

  function automatic bit m_starve();
    return m_cnt == MAX_WAIT;
  endfunction

  function automatic bit m_r0();
    return (!m_ov || out_r) && !(m_starve() && in1_v);
  endfunction

  function automatic bit m_r1();
    return (!m_ov || out_r) && (m_starve() || !in0_v);
  endfunction

  task automatic check_all();
    chk("starve", starve, m_starve());
    chk("in0_ready", in0_r, m_r0());
    chk("in1_ready", in1_r, m_r1());
    chk("out_valid", out_v, m_ov);
    chk("out_way", out_way, m_way);
    chk("out_addr", out_addr, m_addr);
    chk("out_wmask", out_mask, m_mask);
    chk("out_data", out_data, m_data);
  endtask

  task automatic model_step();
    bit f0, f1;
    f0 = in0_v && m_r0();
    f1 = in1_v && m_r1();
    if (!m_ov || out_r) begin
      m_ov = f0 || f1;
      if (f1) begin
        m_way = in1_way; m_addr = in1_addr; m_mask = '1; m_data = in1_data;
      end else if (f0) begin
        m_way = in0_way; m_addr = in0_addr; m_mask = in0_mask; m_data = in0_data;
      end
    end
    if (in1_v && !f1) m_cnt = (m_cnt + 1 > MAX_WAIT) ? MAX_WAIT : m_cnt + 1;
    else              m_cnt = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge clock);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rnd_bits();
    in0_way = WAY_W'(1 << $urandom_range(WAY_W-1)); in0_addr = ADDR_W'($urandom());
    in0_mask = MASK_W'($urandom()); in0_data = rnd_data();
    in1_way = WAY_W'(1 << $urandom_range(WAY_W-1)); in1_addr = ADDR_W'($urandom());
    in1_data = rnd_data();
  endtask

  initial begin
    reset = 1'b0;
    in0_v = 0; in1_v = 0; out_r = 1;
    rnd_bits();
    model_reset();
    #12;
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Reset mid-operation with a held write
    in0_v = 1; out_r = 0; in0_addr = 12'h3C4; tick();
    in0_v = 0;
    #1 chk("held_before_reset", out_v, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_v, 1'b0);
    chk("rst_starve", starve, 1'b0);
    chk("rst_addr", out_addr, '0);
    chk("rst_data", out_data, '0);
    chk("rst_wmask", out_mask, '0);
    model_reset();
    @(negedge clock);
    reset = 1'b1; out_r = 1;
    in0_v = 1; in0_addr = 12'h055; in0_mask = 2'b01; tick();
    in0_v = 0;
    #1 chk("post_reset_addr", out_addr, 12'h055);
    chk("post_reset_valid", out_v, 1'b1);
    tick();

    // Port 1 alone
    in1_v = 1; in1_addr = 12'h123; in1_data = {16{8'hA5}};
    #1 chk("p1_alone_ready", in1_r, 1'b1);
    tick();
    in1_v = 0;
    #1 chk("p1_alone_addr", out_addr, 12'h123);
    chk("p1_alone_wmask", out_mask, 2'b11);
    chk("p1_alone_data", out_data, {16{8'hA5}});
    tick();

    // Starvation sequence: both valid, output always ready
    in0_v = 1; in1_v = 1;
    for (int k = 0; k < 6; k++) begin
      rnd_bits();
      #1 chk("starve_seq_starve", starve, (k == 4));
      chk("starve_seq_r0", in0_r, (k != 4));
      tick();
    end
    in0_v = 0; in1_v = 0; tick();

    // Backpressure with output full
    in0_v = 1; in0_addr = 12'h2AA; tick();
    out_r = 0; in1_v = 1;
    for (int k = 0; k < 3; k++) begin
      rnd_bits();
      #1 chk("bp_r0", in0_r, 1'b0);
      chk("bp_r1", in1_r, 1'b0);
      chk("bp_addr_held", out_addr, 12'h2AA);
      tick();
    end
    out_r = 1; tick();
    in0_v = 0; in1_v = 0; tick(); tick();

    // Back-to-back port-0 writes with distinct masks
    in0_v = 1; in0_mask = 2'b01; in0_addr = 12'h010; tick();
    in0_mask = 2'b10; in0_addr = 12'h020;
    #1 chk("b2b_mask0", out_mask, 2'b01);
    tick();
    in0_v = 0;
    #1 chk("b2b_mask1", out_mask, 2'b10);
    chk("b2b_valid", out_v, 1'b1);
    tick();

    // Port 1 withdraws at cnt=3
    in0_v = 1; in1_v = 1;
    for (int k = 0; k < 3; k++) begin rnd_bits(); tick(); end
    in1_v = 0;
    for (int k = 0; k < 3; k++) begin
      rnd_bits();
      #1 chk("withdraw_no_starve", starve, 1'b0);
      tick();
    end
    in0_v = 0; tick();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rnd_bits();
      in0_v = ($urandom_range(99) < 60);
      in1_v = ($urandom_range(99) < 60);
      out_r = ($urandom_range(99) < 75);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_data_write_sched.md
Name: dcache_data_write_sched

Overview:
- Schedules the shared L1 data-array write port between two requesters:
  - port 0: refill/replay writes, normally high priority, per-bank write mask;
  - port 1: store writeback, full-width mask.
- Fixed priority to port 0, plus an anti-starvation counter that forces a port-1 grant after a bounded wait.
- Winning write is captured in a one-entry registered output stage feeding the data array under ready/valid.

Parameters:
WAY_W, 8, way-enable one-hot width
ADDR_W, 12, data-array row address width
MASK_W, 2, write-mask width (one bit per 64-bit bank)
DATA_W, 128, write data width
MAX_WAIT, 4, consecutive stalled cycles of a valid port-1 request before port 1 gets priority (1..7)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
io_in_0_valid  input  1  port-0 request valid
io_in_0_ready  output  1  port-0 accepted this cycle when high with valid
io_in_0_bits_way_en  input  WAY_W  port-0 way enable
io_in_0_bits_addr  input  ADDR_W  port-0 row address
io_in_0_bits_wmask  input  MASK_W  port-0 bank mask
io_in_0_bits_data  input  DATA_W  port-0 data
io_in_1_valid  input  1  port-1 request valid
io_in_1_ready  output  1  port-1 accepted
io_in_1_bits_way_en  input  WAY_W  port-1 way enable
io_in_1_bits_addr  input  ADDR_W  port-1 row address
io_in_1_bits_data  input  DATA_W  port-1 data
io_out_valid  output  1  registered write valid to data array
io_out_ready  input  1  data array accepts write
io_out_bits_way_en  output  WAY_W  registered way enable
io_out_bits_addr  output  ADDR_W  registered address
io_out_bits_wmask  output  MASK_W  registered mask
io_out_bits_data  output  DATA_W  registered data
io_starve  output  1  high while port 1 holds forced priority

Behaviour:
- Reset (reset low, async): io_out_valid=0, all io_out_bits=0, wait counter=0, io_starve=0. Takes effect immediately mid-transfer; any held write is dropped.
- Load condition: load = !io_out_valid || io_out_ready.
- Priority select: starve = (cnt == MAX_WAIT); io_starve = starve.
  - starve=0: port 0 wins if valid, else port 1.
  - starve=1: port 1 wins if valid, else port 0.
- Readies:
  - io_in_0_ready = load && (starve ? !io_in_1_valid : 1).
  - io_in_1_ready = load && (starve ? 1 : !io_in_0_valid).
  - Readies are combinational and do not depend on their own port's valid.
- Fire: fire_x = io_in_x_valid && io_in_x_ready. At most one fire per cycle.
- Output register, on a clock edge with load=1:
  - io_out_valid <= fire_0 || fire_1.
  - On a fire, bits load from the winner. Port 1 supplies wmask = all ones (MASK_W'b1...1).
  - With no fire, bits hold their previous value.
  - With load=0, the register holds its contents.
- Latency: accepted request appears on io_out one cycle later. Full throughput of one write per cycle when io_out_ready stays high.
- Wait counter cnt, 3 bits:
  - if io_in_1_valid && !fire_1: cnt <= min(cnt+1, MAX_WAIT);
  - else cnt <= 0 (port-1 fire or port 1 idle).
  - Stalls caused by a backpressured output (load=0) also count.
- Simultaneous valids, starve=0: port 0 fires and cnt increments. After MAX_WAIT such cycles, the next loadable cycle grants port 1, cnt clears, and priority returns to port 0.
- Port 1 dropping valid before a grant clears cnt. No forced grant is issued to an absent request.
- Bits change only on an output-register load. Bits are held stable while io_out_valid && !io_out_ready.

Test Plan:
- Reset mid-operation: hold io_out_valid=1 with io_out_ready=0, assert reset low between edges -> io_out_valid=0, bits=0, io_starve=0 immediately; first request after release appears 1 cycle after fire.
- Port 1 alone: in1 valid, addr=0x123, data=0xA5..A5, io_out_ready=1 -> io_in_1_ready=1; next cycle io_out_valid=1, addr=0x123, wmask=2'b11.
- Both valid continuously, io_out_ready=1, MAX_WAIT=4:
  - cycles 0-3 grant port 0 (cnt 1..4);
  - cycle 4 io_starve=1, port 1 granted, io_in_0_ready=0;
  - cycle 5 port 0 again, cnt=0.
- Backpressure: io_out_ready=0 for 3 cycles with output full -> both readies 0, output bits constant, cnt increments while in1 valid; release -> held write drains, new winner loads same edge.
- Back-to-back port-0 writes, wmask=2'b01 then 2'b10, io_out_ready=1 -> io_out shows each on consecutive cycles, no bubble, masks preserved.
- Port 1 withdraws at cnt=3 -> cnt=0 next cycle, io_starve never asserts.
